tnoc_vc_fifo: RTL
=================

Name: tnoc_vc_fifo

Overview:
Multi-channel (virtual-channel) FIFO for router input ports. It holds CHANNELS independent first-word-fall-through queues that share one write port, since one flit arrives per cycle tagged with its VC. Each queue has its own read port and status. It adds per-channel clear, occupancy counts and sticky overflow/underflow error flags, which the single-queue FIFO lacks.

Parameters:
WIDTH, 8, flit/data width in bits
DEPTH, 8, entries per channel; legal DEPTH >= 2
CHANNELS, 2, number of independent queues; legal CHANNELS >= 1
THRESHOLD, DEPTH, per-channel almost-full level; legal 1 <= THRESHOLD <= DEPTH
CW (local), $clog2(DEPTH+1), count width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
i_clear  in  CHANNELS  per-channel synchronous flush
i_push  in  CHANNELS  one-hot write select; all-zero means no write
i_data  in  WIDTH  write data, shared by all channels
i_pop  in  CHANNELS  per-channel read strobe; multi-hot allowed
o_data  out  CHANNELS*WIDTH  head entry of channel c at [c*WIDTH +: WIDTH]
o_empty  out  CHANNELS  channel holds 0 entries
o_almost_full  out  CHANNELS  count >= THRESHOLD
o_full  out  CHANNELS  count == DEPTH
o_count  out  CHANNELS*CW  occupancy of channel c at [c*CW +: CW]
o_overflow  out  CHANNELS  sticky: a push was dropped on this channel
o_underflow  out  CHANNELS  sticky: a pop was issued while the channel was empty

Behaviour:
- Reset, asynchronous and active-high: every channel empty; o_empty all 1; o_full, o_almost_full, o_count, o_overflow, o_underflow and o_data all 0.
- Storage per channel: circular buffer with read/write pointers that wrap DEPTH-1 -> 0. Any DEPTH is allowed, including non-power-of-2, so wrap is an explicit compare, not a bit truncation.
- Push accepted on channel c when i_push[c]=1 and (count<DEPTH or i_pop[c]=1) and i_clear[c]=0.
- Accepted data appears on o_data[c] in cycle t+1 if the queue was empty, or when it reaches the head. Write-to-read latency is 1 cycle; there is no combinational path from i_data to o_data.
- Pop accepted on c when i_pop[c]=1 and count>0 and i_clear[c]=0. The head advances and the next entry is visible the following cycle.
- o_data[c] is combinational from storage at the read pointer, forced to 0 while o_empty[c]=1.
- Count update: count += push_acc - pop_acc. It never exceeds DEPTH and never goes below 0.
- Status outputs are registered-state derived: flags reflect count after the edge and have no combinational dependency on i_push/i_pop.
- Full channel + push + pop in the same cycle: both accepted, count stays DEPTH, no overflow.
- Empty channel + push + pop in the same cycle: pop ignored, o_underflow set, push accepted, count becomes 1.
- Push to a full channel without a pop: data dropped, storage unchanged, o_overflow[c] set.
- Pop on an empty channel: ignored, o_underflow[c] set.
- i_push not one-hot (more than one bit set): no channel is written, and o_overflow is set on every selected channel. A simulation assertion flags it.
- i_clear[c]=1: the next cycle channel c is empty with pointers 0, count 0, and o_overflow[c]/o_underflow[c] cleared. A push or pop to c in the same cycle is discarded and sets no flag. Other channels are unaffected.
- Reset asserted mid-operation: immediate return to reset state regardless of clock. Contents are lost.
- Channels are fully independent: a push to one channel and pops on any others proceed in the same cycle.

Test Plan:
1. CHANNELS=2, DEPTH=4: reset, push 0xA1,0xA2 to ch0 and 0xB1 to ch1 -> ch0 count=2 with head 0xA1, ch1 count=1 with head 0xB1; pop both -> heads 0xA2 and empty/0x00.
2. Fill ch0 with 0x01..0x04 -> o_full[0]=1, almost_full at THRESHOLD=3 asserts after the 3rd push. A 5th push with no pop sets o_overflow[0] and the head stays 0x01. Then push 0x05 with pop -> count stays 4; drain order 0x02,0x03,0x04,0x05.
3. Wrap: DEPTH=3 (non-power-of-2), 10 push/pop cycles of sequential data -> FIFO order preserved, count never >3.
4. Empty ch1 with push 0x77 and pop in the same cycle -> o_underflow[1]=1, count=1, head=0x77 next cycle.
5. ch0 count=3 with i_clear[0] and i_push[0] in the same cycle -> ch0 empty, flags 0, ch1 contents and count unchanged.
6. i_push=2'b11 -> counts unchanged, o_overflow=2'b11, assertion fires. Reset pulse mid-fill -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/tnoc_vc_fifo_if.sv
// Handshake bundle for the multi-channel VC FIFO.
// master drives writes/reads/clears, slave returns per-channel status.
interface tnoc_vc_fifo_if #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CHANNELS-1:0]       i_clear;
  logic [CHANNELS-1:0]       i_push;
  logic [WIDTH-1:0]          i_data;
  logic [CHANNELS-1:0]       i_pop;
  logic [CHANNELS*WIDTH-1:0] o_data;
  logic [CHANNELS-1:0]       o_empty;
  logic [CHANNELS-1:0]       o_almost_full;
  logic [CHANNELS-1:0]       o_full;
  logic [CHANNELS*CW-1:0]    o_count;
  logic [CHANNELS-1:0]       o_overflow;
  logic [CHANNELS-1:0]       o_underflow;

  modport master (
    output i_clear, i_push, i_data, i_pop,
    input  o_data, o_empty, o_almost_full, o_full,
    input  o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_clear, i_push, i_data, i_pop,
    output o_data, o_empty, o_almost_full, o_full,
    output o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/tnoc_vc_fifo.sv
// Virtual-channel FIFO: CHANNELS independent FWFT queues sharing one
// write port, with per-channel clear, occupancy and sticky error flags.
module tnoc_vc_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int CHANNELS  = 2,
  parameter int THRESHOLD = DEPTH
) (
  input logic           clk,
  input logic           rst,
  tnoc_vc_fifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic             push_multi;
  logic [WIDTH-1:0] head  [CHANNELS];
  logic [CW-1:0]    cnt_w [CHANNELS];
  logic             ovf_w [CHANNELS];
  logic             udf_w [CHANNELS];

  // More than one push bit set means an illegal write: nothing is stored.
  assign push_multi =
    |(bus.i_push & (bus.i_push - CHANNELS'(1)));

  // Pointer advance with explicit wrap so any DEPTH works.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, rp;
    logic [CW-1:0]    cnt;
    logic             ovf, udf;
    logic             clr, full, empty;
    logic             push_acc, pop_acc, ovf_set, udf_set;

    assign clr      = bus.i_clear[c];
    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign pop_acc  = bus.i_pop[c] & ~empty & ~clr;
    assign push_acc = bus.i_push[c] & ~push_multi & ~clr
                    & (~full | bus.i_pop[c]);
    assign ovf_set  = bus.i_push[c] & ~clr
                    & (push_multi | (full & ~bus.i_pop[c]));
    assign udf_set  = bus.i_pop[c] & empty & ~clr;

    // Storage write; contents are masked by o_empty so need no reset.
    always_ff @(posedge clk) begin
      if (push_acc) mem[wp] <= bus.i_data;
    end

    // Pointers, occupancy and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        ovf <= 1'b0;
        udf <= 1'b0;
      end else if (clr) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (push_acc) wp <= inc(wp);
        if (pop_acc)  rp <= inc(rp);
        cnt <= cnt + CW'(push_acc) - CW'(pop_acc);
        if (ovf_set)  ovf <= 1'b1;
        if (udf_set)  udf <= 1'b1;
      end
    end

    assign head[c]  = empty ? '0 : mem[rp];
    assign cnt_w[c] = cnt;
    assign ovf_w[c] = ovf;
    assign udf_w[c] = udf;
  end

  // Pack per-channel state onto the flat status buses.
  always_comb begin
    bus.o_data        = '0;
    bus.o_count       = '0;
    bus.o_empty       = '0;
    bus.o_full        = '0;
    bus.o_almost_full = '0;
    bus.o_overflow    = '0;
    bus.o_underflow   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      bus.o_data[c*WIDTH +: WIDTH] = head[c];
      bus.o_count[c*CW +: CW]      = cnt_w[c];
      bus.o_empty[c]       = (cnt_w[c] == '0);
      bus.o_full[c]        = (cnt_w[c] == CW'(DEPTH));
      bus.o_almost_full[c] = (cnt_w[c] >= CW'(THRESHOLD));
      bus.o_overflow[c]    = ovf_w[c];
      bus.o_underflow[c]   = udf_w[c];
    end
  end

  // Flag illegal multi-hot writes in simulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!push_multi)
        else $warning("tnoc_vc_fifo: i_push not one-hot");
    end
  end
endmodule
